// File: rtl/alu_uart_interface_if.sv
// ---------------------------------------------------------------------------
// alu_uart_interface_if
// Bundles the byte-level signals between the UART receiver/transmitter, the
// combinational ALU and the alu_uart_interface sequencer.
//
// Parameters:
//   DATA_WIDTH : operand, result and UART byte width (>= OP_WIDTH)
//   OP_WIDTH   : ALU opcode width
//
// Signals (direction as seen by the sequencer, modport slave):
//   rx_dato     in  : received byte, valid when rx_done=1
//   rx_done     in  : one-cycle pulse, one byte received
//   tx_done     in  : one-cycle pulse, transmitter finished
//   resultado   in  : combinational ALU result
//   dato_A      out : registered operand A to the ALU
//   dato_B      out : registered operand B to the ALU
//   op          out : registered opcode to the ALU
//   tx_dato     out : registered result byte for the transmitter
//   tx_start    out : one-cycle transmit request
//   ocupado     out : high while a result is being computed/sent
//   op_invalido out : one-cycle invalid-opcode pulse
// ---------------------------------------------------------------------------
interface alu_uart_interface_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
);
   logic [DATA_WIDTH-1:0] rx_dato;
   logic                  rx_done;
   logic                  tx_done;
   logic [DATA_WIDTH-1:0] resultado;
   logic [DATA_WIDTH-1:0] dato_A;
   logic [DATA_WIDTH-1:0] dato_B;
   logic [OP_WIDTH-1:0]   op;
   logic [DATA_WIDTH-1:0] tx_dato;
   logic                  tx_start;
   logic                  ocupado;
   logic                  op_invalido;

   modport slave (
      input  rx_dato, rx_done, tx_done, resultado,
      output dato_A, dato_B, op, tx_dato, tx_start, ocupado, op_invalido
   );

   modport master (
      output rx_dato, rx_done, tx_done, resultado,
      input  dato_A, dato_B, op, tx_dato, tx_start, ocupado, op_invalido
   );
endinterface

// File: rtl/alu_uart_interface.sv
// ---------------------------------------------------------------------------
// alu_uart_interface
// Sequencer between a UART and a combinational ALU. It collects three bytes
// (operand A, operand B, opcode), presents them as registered ALU inputs,
// captures the ALU result and requests its transmission with a one-cycle
// tx_start pulse, then waits for tx_done before accepting the next frame.
//
// Parameters:
//   DATA_WIDTH : operand, result and UART byte width (>= OP_WIDTH)
//   OP_WIDTH   : ALU opcode width
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : alu_uart_interface_if.slave (see interface file for signals)
//
// Optional feature (macro ALU_INTERFACE_OPCHECK_EN):
//   When defined, an opcode byte outside the supported ALU set is rejected:
//   op is kept, op_invalido pulses for one cycle and the FSM keeps waiting
//   for an opcode with A and B retained. When undefined, every opcode is
//   forwarded and op_invalido stays 0.
// ---------------------------------------------------------------------------
module alu_uart_interface #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_uart_interface_if.slave   bus
);

   typedef enum logic [2:0] {
      ESPERA_A,
      ESPERA_B,
      ESPERA_OP,
      CALCULO,
      ENVIO,
      ESPERA_TX
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] dato_a_r;
   logic [DATA_WIDTH-1:0] dato_b_r;
   logic [OP_WIDTH-1:0]   op_r;
   logic [DATA_WIDTH-1:0] tx_dato_r;
   logic                  tx_start_r;
   logic                  ocupado_r;
   logic                  op_inv_r;

`ifdef ALU_INTERFACE_OPCHECK_EN
   // Opcodes the downstream ALU implements.
   function automatic logic op_valid(input logic [OP_WIDTH-1:0] code);
      logic ok;
      case (code)
         OP_WIDTH'('h20), OP_WIDTH'('h22), OP_WIDTH'('h24), OP_WIDTH'('h25),
         OP_WIDTH'('h26), OP_WIDTH'('h03), OP_WIDTH'('h02), OP_WIDTH'('h27):
            ok = 1'b1;
         default:
            ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ESPERA_A;
         dato_a_r   <= '0;
         dato_b_r   <= '0;
         op_r       <= '0;
         tx_dato_r  <= '0;
         tx_start_r <= 1'b0;
         ocupado_r  <= 1'b0;
         op_inv_r   <= 1'b0;
      end else begin
         // Pulse outputs default low; they are raised only on the transition
         // into the cycle where they must be seen.
         tx_start_r <= 1'b0;
         op_inv_r   <= 1'b0;
         case (state)
            ESPERA_A: begin
               if (bus.rx_done) begin
                  dato_a_r <= bus.rx_dato;
                  state    <= ESPERA_B;
               end
            end
            ESPERA_B: begin
               if (bus.rx_done) begin
                  dato_b_r <= bus.rx_dato;
                  state    <= ESPERA_OP;
               end
            end
            ESPERA_OP: begin
               if (bus.rx_done) begin
`ifdef ALU_INTERFACE_OPCHECK_EN
                  if (op_valid(bus.rx_dato[OP_WIDTH-1:0])) begin
                     op_r      <= bus.rx_dato[OP_WIDTH-1:0];
                     state     <= CALCULO;
                     ocupado_r <= 1'b1;
                  end else begin
                     op_inv_r  <= 1'b1;
                  end
`else
                  op_r      <= bus.rx_dato[OP_WIDTH-1:0];
                  state     <= CALCULO;
                  ocupado_r <= 1'b1;
`endif
               end
            end
            CALCULO: begin
               // ALU inputs settled during this cycle; latch its output and
               // raise tx_start for exactly the ENVIO cycle.
               tx_dato_r  <= bus.resultado;
               tx_start_r <= 1'b1;
               state      <= ENVIO;
            end
            ENVIO: begin
               state <= ESPERA_TX;
            end
            ESPERA_TX: begin
               // A coincident rx_done is dropped: no byte is captured here.
               if (bus.tx_done) begin
                  state     <= ESPERA_A;
                  ocupado_r <= 1'b0;
               end
            end
            default: begin
               state     <= ESPERA_A;
               ocupado_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dato_A   = dato_a_r;
   assign bus.dato_B   = dato_b_r;
   assign bus.op       = op_r;
   assign bus.tx_dato  = tx_dato_r;
   assign bus.tx_start = tx_start_r;
   assign bus.ocupado  = ocupado_r;
`ifdef ALU_INTERFACE_OPCHECK_EN
   assign bus.op_invalido = op_inv_r;
`else
   assign bus.op_invalido = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_interface.sv
module tb_alu_uart_interface;
   localparam int DW = 8;
   localparam int OW = 6;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   txcnt  = 0;

   alu_uart_interface_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

   alu_uart_interface #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: MIPS-style function codes on 8-bit operands.
   function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] o);
      logic signed [DW-1:0] sa;
      sa = a;
      case (o)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h03:   return sa >>> b;
         6'h02:   return a >> b;
         6'h27:   return ~(a | b);
         default: return '0;
      endcase
   endfunction

   always_comb bus.resultado = alu_ref(bus.dato_A, bus.dato_B, bus.op);

   always @(posedge clk) if (bus.tx_start) txcnt <= txcnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One rx_done pulse; starts and ends at a falling edge.
   task automatic send(input logic [7:0] b);
      bus.rx_dato = b;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_done = 1'b0;
   endtask

   // Checks from the cycle after the opcode edge through tx_done.
   task automatic post_op(input logic [7:0] obyte, input logic [7:0] expv,
                          input int txwait, input bit drop, input logic [7:0] a_now);
      int start_cnt;
      start_cnt = txcnt;
      chk("op", 32'(bus.op), 32'(obyte[OW-1:0]));
      chk("ocupado_calc", 32'(bus.ocupado), 1);
      chk("tx_start_early", 32'(bus.tx_start), 0);
      chk("op_invalido_ok", 32'(bus.op_invalido), 0);
      tick();
      chk("tx_start_pulse", 32'(bus.tx_start), 1);
      chk("tx_dato", 32'(bus.tx_dato), 32'(expv));
      tick();
      chk("tx_start_end", 32'(bus.tx_start), 0);
      repeat (txwait) tick();
      if (drop) begin
         send(8'h77);
         chk("drop_busy", 32'(bus.ocupado), 1);
         bus.rx_dato = 8'h55;
         bus.rx_done = 1'b1;
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      bus.rx_done = 1'b0;
      chk("idle_after_tx", 32'(bus.ocupado), 0);
      chk("a_kept", 32'(bus.dato_A), 32'(a_now));
      chk("one_start", 32'(txcnt - start_cnt), 1);
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                        input int txwait, input bit drop);
      send(a);
      chk("dato_A", 32'(bus.dato_A), 32'(a));
      send(b);
      chk("dato_B", 32'(bus.dato_B), 32'(b));
      chk("ocupado_rx", 32'(bus.ocupado), 0);
      send(o);
      post_op(o, alu_ref(a, b, o[OW-1:0]), txwait, drop, a);
   endtask

   task automatic b2b(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                      input logic [7:0] expv);
      bus.rx_dato = a;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_dato = b;
      tick();
      bus.rx_dato = o;
      tick();
      bus.rx_done = 1'b0;
      chk("b2b_A", 32'(bus.dato_A), 32'(a));
      chk("b2b_B", 32'(bus.dato_B), 32'(b));
      post_op(o, expv, 2, 1'b0, a);
   endtask

   logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

   initial begin
      logic [7:0] ra, rb, ro;
      reset       = 1'b1;
      bus.rx_dato = '0;
      bus.rx_done = 1'b0;
      bus.tx_done = 1'b0;
      repeat (3) tick();
      chk("rst_A", 32'(bus.dato_A), 0);
      chk("rst_B", 32'(bus.dato_B), 0);
      chk("rst_op", 32'(bus.op), 0);
      chk("rst_txd", 32'(bus.tx_dato), 0);
      chk("rst_txs", 32'(bus.tx_start), 0);
      chk("rst_ocup", 32'(bus.ocupado), 0);
      chk("rst_inv", 32'(bus.op_invalido), 0);
      reset = 1'b0;
      tick();

      // Add
      frame(8'h05, 8'h03, 8'h20, 3, 1'b0);
      chk("add_result", 32'(bus.tx_dato), 32'h08);

      // Back-to-back byte pulses, subtract wrap then AND
      b2b(8'h03, 8'h05, 8'h22, 8'hFE);
      b2b(8'hF0, 8'h3C, 8'h24, 8'h30);

      // Opcode upper bits discarded
      frame(8'h0F, 8'hF0, 8'hE5, 0, 1'b0);
      chk("or_op", 32'(bus.op), 32'h25);
      chk("or_result", 32'(bus.tx_dato), 32'hFF);

      // Bytes during ESPERA_TX and coincident with tx_done are dropped
      frame(8'h09, 8'h06, 8'h26, 2, 1'b1);
      frame(8'h01, 8'h02, 8'h26, 1, 1'b0);
      chk("xor_result", 32'(bus.tx_dato), 32'h03);

      // tx_done while idle is ignored
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("stray_txdone", 32'(bus.ocupado), 0);

      // Reset mid-frame
      send(8'h11);
      send(8'h22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_A", 32'(bus.dato_A), 0);
      chk("mid_rst_B", 32'(bus.dato_B), 0);
      chk("mid_rst_op", 32'(bus.op), 0);
      chk("mid_rst_txd", 32'(bus.tx_dato), 0);
      chk("mid_rst_txs", 32'(bus.tx_start), 0);
      chk("mid_rst_ocup", 32'(bus.ocupado), 0);
      frame(8'h04, 8'h01, 8'h20, 1, 1'b0);
      chk("after_rst_result", 32'(bus.tx_dato), 32'h05);

      // Opcode check
`ifdef ALU_INTERFACE_OPCHECK_EN
      send(8'h0C);
      send(8'h30);
      send(8'h3F);
      chk("inv_pulse", 32'(bus.op_invalido), 1);
      chk("inv_op_kept", 32'(bus.op), 32'h20);
      chk("inv_not_busy", 32'(bus.ocupado), 0);
      tick();
      chk("inv_pulse_end", 32'(bus.op_invalido), 0);
      chk("inv_no_start", 32'(bus.tx_start), 0);
      tick();
      chk("inv_no_start2", 32'(bus.tx_start), 0);
      send(8'h25);
      post_op(8'h25, 8'h3C, 1, 1'b0, 8'h0C);
      chk("inv_then_or", 32'(bus.tx_dato), 32'h3C);
`else
      frame(8'h0C, 8'h30, 8'h3F, 1, 1'b0);
      chk("unsup_zero", 32'(bus.tx_dato), 32'h00);
`endif

      // Randomized frames against the reference ALU
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = ops[$urandom_range(0, 7)] | 8'($urandom_range(0, 3) << 6);
         frame(ra, rb, ro, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
